menu_state_fsm: RTL
===================

# menu_state_fsm

Game-flow sequencer that drives the menu/countdown overlay. It converts the player's mode and start buttons into the menu state signals: menu active, countdown active, countdown value 3/2/1/0 and the selected mode. It also hands control to the game core with a start pulse, and returns to the menu when the game core signals game over. It sits between the button inputs and the menu graphics block, in the pixel_clk domain.

## Interface
- COUNT_TICKS, default 25_000_000: pixel_clk cycles each countdown value is held (1 s at 25 MHz); legal range ≥ 2.
- pixel_clk  in  1  25 MHz pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- btn_mode  in  1  debounced, asynchronous mode-toggle button, high = pressed.
- btn_start  in  1  debounced, asynchronous start button, high = pressed.
- game_over  in  1  synchronous to pixel_clk, from the game core; level, sampled only in PLAY.
- menu_active  out  1  high in MENU.
- countdown_active  out  1  high in COUNTDOWN.
- countdown_value  out  8  3, 2, 1, then 0 (START text) during COUNTDOWN; holds 3 otherwise.
- game_mode_1p  out  1  1 = one-player mode, 0 = two-player mode.
- game_active  out  1  high in PLAY.
- game_start_pulse  out  1  single-cycle pulse on entry to PLAY.

## Operation
- Button conditioning, per button:
  - 2-flop synchronizer s1→s2, then a history flop s3.
  - Rise = s2 & ~s3.
  - All three flops reset to 1. A button held through reset produces no rise until it is released and pressed again.
- States:
  - MENU (reset state).
  - COUNTDOWN.
  - PLAY.
  - Encoding is free. Outputs are registered and decoded so that exactly one of menu_active, countdown_active, game_active is high at all times after reset.
- MENU:
  - Rise on btn_mode toggles game_mode_1p.
  - Rise on btn_start → COUNTDOWN, with countdown_value=3 and tick counter cleared.
  - Both rises in the same cycle: start wins and the mode is not toggled.
- COUNTDOWN:
  - Tick counter, width clog2(COUNT_TICKS), counts 0..COUNT_TICKS-1 and wraps to 0.
  - On wrap, countdown_value decrements 3→2→1→0.
  - Wrap while countdown_value=0 → PLAY, with countdown_value reloaded to 3 and game_start_pulse=1.
  - btn_mode and btn_start rises are ignored.
  - game_mode_1p is frozen.
- PLAY:
  - game_over=1 → MENU at the next edge; game_mode_1p is retained.
  - Button rises are ignored.
- game_over is ignored in MENU and COUNTDOWN.
- Reset values:
  - menu_active=1, countdown_active=0, countdown_value=8'd3, game_mode_1p=1, game_active=0, game_start_pulse=0.
  - Tick counter 0.
  - Reset asserted in any state, including mid-countdown, forces these values at the next edge.

## Timing
- Button latency: btn first sampled high at edge E, having been low at E-1 → state/output change at edge E+2.
- Countdown, entered at edge C:
  - value 3 during [C, C+T); 2 at C+T; 1 at C+2T; 0 at C+3T, with T=COUNT_TICKS.
  - PLAY, game_active=1 and game_start_pulse=1 at C+4T.
  - game_start_pulse deasserts at C+4T+1.
- Each countdown value is held exactly T cycles; total countdown is 4T cycles.
- game_over high at edge G while in PLAY → menu_active=1 and game_active=0 after G.
- A btn_start rise pending in the cycle PLAY→MENU occurs is dropped. A new press is required after arriving in MENU.

## Test plan
- Reset → menu_active=1, countdown_active=0, game_active=0, game_mode_1p=1, countdown_value=3.
- With btn_start held from before reset release, no COUNTDOWN. Release then press → COUNTDOWN entered 2 edges after first high sample.
- MENU, three btn_mode presses (each held 5 cycles, 5 low) → game_mode_1p 1→0→1→0.
- btn_mode and btn_start rising together → COUNTDOWN, game_mode_1p unchanged.
- COUNT_TICKS=4, start press:
  - countdown_value 3,2,1,0, each exactly 4 cycles.
  - Then game_active=1, game_start_pulse high exactly 1 cycle at entry+16.
  - Mode presses during the countdown leave game_mode_1p unchanged.
- PLAY, assert game_over 1 cycle → MENU next edge with game_mode_1p preserved. game_over pulses in MENU/COUNTDOWN → no effect.
- Reset asserted at countdown_value=1 → next edge all outputs at reset values, including game_mode_1p=1. A subsequent start press gives a full 4T countdown.

Source files
------------

// File: rtl/menu_state_fsm.sv
// menu_state_fsm: menu/countdown/play sequencer with button edge detection and a timed 3-2-1-0 countdown
module menu_state_fsm #(
  parameter int COUNT_TICKS = 25_000_000
) (
  input  logic       pixel_clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_start,
  input  logic       game_over,
  output logic       menu_active,
  output logic       countdown_active,
  output logic [7:0] countdown_value,
  output logic       game_mode_1p,
  output logic       game_active,
  output logic       game_start_pulse
);
  localparam int CW = $clog2(COUNT_TICKS);
  typedef enum logic [1:0] {MENU, COUNTDOWN, PLAY} state_t;
  state_t state, state_n;
  logic [1:0] s1, s2, s3, rise;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] value_n;
  logic mode_n, pulse_n, wrap;
  assign rise = s2 & ~s3;
  assign wrap = cnt == CW'(COUNT_TICKS - 1);
  always_ff @(posedge pixel_clk)
    if (reset) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
      state <= MENU;
      cnt <= '0;
      countdown_value <= 8'd3;
      game_mode_1p <= 1'b1;
      game_start_pulse <= 1'b0;
      menu_active <= 1'b1;
      countdown_active <= 1'b0;
      game_active <= 1'b0;
    end else begin
      s1 <= {btn_start, btn_mode};
      s2 <= s1;
      s3 <= s2;
      state <= state_n;
      cnt <= cnt_n;
      countdown_value <= value_n;
      game_mode_1p <= mode_n;
      game_start_pulse <= pulse_n;
      menu_active <= state_n == MENU;
      countdown_active <= state_n == COUNTDOWN;
      game_active <= state_n == PLAY;
    end
  always_comb begin
    state_n = state;
    cnt_n = '0;
    value_n = countdown_value;
    mode_n = game_mode_1p;
    pulse_n = 1'b0;
    case (state)
      MENU: begin
        if (rise[1]) begin
          state_n = COUNTDOWN;
          value_n = 8'd3;
        end else if (rise[0]) mode_n = ~game_mode_1p;
      end
      COUNTDOWN: begin
        cnt_n = wrap ? '0 : cnt + 1'b1;
        if (wrap && countdown_value == 8'd0) begin
          state_n = PLAY;
          value_n = 8'd3;
          pulse_n = 1'b1;
        end else if (wrap) value_n = countdown_value - 8'd1;
      end
      PLAY: state_n = game_over ? MENU : PLAY;
      default: state_n = MENU;
    endcase
  end
endmodule
